// File: rtl/jtag_ir_dr_chain_if.sv
// Bundle between the TAP controller side and the IR/DR chain: state qualifiers, serial data and parallel user ports.
// master = TAP/driver side, slave = the IR/DR chain.
interface jtag_ir_dr_chain_if #(
    parameter int IR_LEN   = 4,
    parameter int USER_LEN = 8
);
    logic                Resetn;
    logic                TDI;
    logic                CaptureIR;
    logic                ShiftIR;
    logic                UpdateIR;
    logic                CaptureDR;
    logic                ShiftDR;
    logic                UpdateDR;
    logic [USER_LEN-1:0] UserDRIn;
    logic                TDO;
    logic                TDOEn;
    logic [IR_LEN-1:0]   Instruction;
    logic [USER_LEN-1:0] UserDROut;
    logic                UserUpdate;

    modport master (
        output Resetn, TDI, CaptureIR, ShiftIR, UpdateIR,
               CaptureDR, ShiftDR, UpdateDR, UserDRIn,
        input  TDO, TDOEn, Instruction, UserDROut, UserUpdate
    );

    modport slave (
        input  Resetn, TDI, CaptureIR, ShiftIR, UpdateIR,
               CaptureDR, ShiftDR, UpdateDR, UserDRIn,
        output TDO, TDOEn, Instruction, UserDROut, UserUpdate
    );
endinterface

// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction register, BYPASS/IDCODE/USER data registers and TDO mux behind a TAP controller.
// Latency: registers act on the posedge TCK qualified by the TAP state; TDO/TDOEn update on negedge TCK.
// Backpressure: none; the TAP qualifiers pace every shift, one bit per TCK.
module jtag_ir_dr_chain #(
    parameter int                IR_LEN    = 4,
    parameter logic [31:0]       IDCODE    = 32'h0BA0_0477,
    parameter logic [IR_LEN-1:0] OP_IDCODE = 4'b0001,
    parameter logic [IR_LEN-1:0] OP_USER   = 4'b0010,
    parameter int                USER_LEN  = 8
) (
    input logic             TCK,
    input logic             TRSTn,
    jtag_ir_dr_chain_if.slave jif
);

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_e;

    logic [IR_LEN-1:0]   ir_sr_q,    ir_sr_d;
    logic [IR_LEN-1:0]   instr_q,    instr_d;
    logic                bypass_q,   bypass_d;
    logic [31:0]         id_sr_q,    id_sr_d;
    logic [USER_LEN-1:0] user_sr_q,  user_sr_d;
    logic [USER_LEN-1:0] user_out_q, user_out_d;
    logic                user_upd_q, user_upd_d;
    logic                tdo_q,      tdo_d;
    logic                tdoen_q,    tdoen_d;

    dr_sel_e             dr_sel;
    logic                sel_bit;
    logic [IR_LEN-1:0]   ir_shift;
    logic [USER_LEN-1:0] user_shift;

    always_comb begin
        dr_sel  = SEL_BYPASS;
        sel_bit = bypass_q;
        if (instr_q == OP_IDCODE) begin
            dr_sel  = SEL_IDCODE;
            sel_bit = id_sr_q[0];
        end else if (instr_q == OP_USER) begin
            dr_sel  = SEL_USER;
            sel_bit = user_sr_q[0];
        end
    end

    // Shift-right with TDI into the MSB, written so a 1-bit register still elaborates.
    always_comb begin
        ir_shift               = ir_sr_q >> 1;
        ir_shift[IR_LEN-1]     = jif.TDI;
        user_shift             = user_sr_q >> 1;
        user_shift[USER_LEN-1] = jif.TDI;
    end

    always_comb begin
        ir_sr_d    = ir_sr_q;
        instr_d    = instr_q;
        bypass_d   = bypass_q;
        id_sr_d    = id_sr_q;
        user_sr_d  = user_sr_q;
        user_out_d = user_out_q;
        user_upd_d = 1'b0;
        if (!jif.Resetn) begin
            instr_d = OP_IDCODE;
        end else if (jif.CaptureIR) begin
            ir_sr_d = IR_LEN'(1);
        end else if (jif.ShiftIR) begin
            ir_sr_d = ir_shift;
        end else if (jif.UpdateIR) begin
            instr_d = ir_sr_q;
        end else if (jif.CaptureDR) begin
            case (dr_sel)
                SEL_IDCODE: id_sr_d   = IDCODE;
                SEL_USER:   user_sr_d = jif.UserDRIn;
                default:    bypass_d  = 1'b0;
            endcase
        end else if (jif.ShiftDR) begin
            case (dr_sel)
                SEL_IDCODE: id_sr_d   = {jif.TDI, id_sr_q[31:1]};
                SEL_USER:   user_sr_d = user_shift;
                default:    bypass_d  = jif.TDI;
            endcase
        end else if (jif.UpdateDR && dr_sel == SEL_USER) begin
            user_out_d = user_sr_q;
            user_upd_d = 1'b1;
        end
    end

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            ir_sr_q    <= '0;
            instr_q    <= OP_IDCODE;
            bypass_q   <= 1'b0;
            id_sr_q    <= '0;
            user_sr_q  <= '0;
            user_out_q <= '0;
            user_upd_q <= 1'b0;
        end else begin
            ir_sr_q    <= ir_sr_d;
            instr_q    <= instr_d;
            bypass_q   <= bypass_d;
            id_sr_q    <= id_sr_d;
            user_sr_q  <= user_sr_d;
            user_out_q <= user_out_d;
            user_upd_q <= user_upd_d;
        end
    end

    // Falling-edge launch presents the outgoing bit half a cycle before the shifting posedge.
    always_comb begin
        tdoen_d = jif.ShiftIR | jif.ShiftDR;
        tdo_d   = tdo_q;
        if (jif.ShiftIR) begin
            tdo_d = ir_sr_q[0];
        end else if (jif.ShiftDR) begin
            tdo_d = sel_bit;
        end
    end

    always_ff @(negedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            tdo_q   <= 1'b0;
            tdoen_q <= 1'b0;
        end else begin
            tdo_q   <= tdo_d;
            tdoen_q <= tdoen_d;
        end
    end

    assign jif.TDO         = tdo_q;
    assign jif.TDOEn       = tdoen_q;
    assign jif.Instruction = instr_q;
    assign jif.UserDROut   = user_out_q;
    assign jif.UserUpdate  = user_upd_q;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Scoreboard bench for jtag_ir_dr_chain: directed scenarios plus random IR/DR traffic against a bit-level model.
module tb_jtag_ir_dr_chain;

    logic TCK;
    logic TRSTn;

    jtag_ir_dr_chain_if #(.IR_LEN(4), .USER_LEN(8)) jif ();

    jtag_ir_dr_chain dut (
        .TCK   (TCK),
        .TRSTn (TRSTn),
        .jif   (jif)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic exp_q[$];

    // Reference model state
    logic [3:0]  m_ir;
    logic [3:0]  m_instr;
    logic        m_byp;
    logic [31:0] m_id;
    logic [7:0]  m_user;
    logic [7:0]  m_userout;

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every posedge with TDO enabled is one bit leaving the chain.
    always @(posedge TCK) begin
        if (TRSTn && jif.TDOEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("tdo_unexpected_enable", 32'(jif.TDOEn), 32'd0);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("tdo_bit", 32'(jif.TDO), 32'(e));
            end
        end
    end

    function automatic int msel(input logic [3:0] ins);
        if (ins == 4'b0001) return 1;
        if (ins == 4'b0010) return 2;
        return 0;
    endfunction

    task automatic cyc();
        @(posedge TCK);
        #1;
    endtask

    task automatic model_reset();
        m_ir      = 4'h0;
        m_instr   = 4'b0001;
        m_byp     = 1'b0;
        m_id      = 32'h0;
        m_user    = 8'h00;
        m_userout = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic capture_ir();
        jif.CaptureIR = 1'b1;
        cyc();
        jif.CaptureIR = 1'b0;
        m_ir = 4'b0001;
    endtask

    task automatic shift_ir(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            jif.ShiftIR = 1'b1;
            jif.TDI     = d[i];
            exp_q.push_back(m_ir[0]);
            m_ir = {d[i], m_ir[3:1]};
            cyc();
        end
        jif.ShiftIR = 1'b0;
    endtask

    task automatic update_ir();
        jif.UpdateIR = 1'b1;
        cyc();
        jif.UpdateIR = 1'b0;
        m_instr = m_ir;
        chk("instruction_after_update", 32'(jif.Instruction), 32'(m_instr));
    endtask

    task automatic load_ir(input logic [3:0] op);
        capture_ir();
        shift_ir(64'(op), 4);
        update_ir();
    endtask

    task automatic capture_dr();
        jif.CaptureDR = 1'b1;
        cyc();
        jif.CaptureDR = 1'b0;
        case (msel(m_instr))
            1:       m_id   = 32'h0BA0_0477;
            2:       m_user = jif.UserDRIn;
            default: m_byp  = 1'b0;
        endcase
    endtask

    // pause_at < 0 means no pause; otherwise two idle cycles are inserted before bit pause_at.
    task automatic shift_dr(input logic [63:0] d, input int n, input int pause_at);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                jif.ShiftDR = 1'b0;
                idle(2);
            end
            jif.ShiftDR = 1'b1;
            jif.TDI     = d[i];
            case (msel(m_instr))
                1: begin
                    exp_q.push_back(m_id[0]);
                    m_id = {d[i], m_id[31:1]};
                end
                2: begin
                    exp_q.push_back(m_user[0]);
                    m_user = {d[i], m_user[7:1]};
                end
                default: begin
                    exp_q.push_back(m_byp);
                    m_byp = d[i];
                end
            endcase
            cyc();
        end
        jif.ShiftDR = 1'b0;
    endtask

    task automatic update_dr();
        logic pulse;
        pulse = (msel(m_instr) == 2);
        jif.UpdateDR = 1'b1;
        cyc();
        jif.UpdateDR = 1'b0;
        if (pulse) m_userout = m_user;
        chk("user_update_pulse", 32'(jif.UserUpdate), 32'(pulse));
        chk("user_dr_out", 32'(jif.UserDROut), 32'(m_userout));
        cyc();
        chk("user_update_cleared", 32'(jif.UserUpdate), 32'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [3:0]  op;
        int          n;
        int          p;

        TRSTn         = 1'b0;
        jif.Resetn    = 1'b1;
        jif.TDI       = 1'b0;
        jif.CaptureIR = 1'b0;
        jif.ShiftIR   = 1'b0;
        jif.UpdateIR  = 1'b0;
        jif.CaptureDR = 1'b0;
        jif.ShiftDR   = 1'b0;
        jif.UpdateDR  = 1'b0;
        jif.UserDRIn  = 8'hA5;
        model_reset();
        idle(2);

        // Reset values
        chk("rst_instruction", 32'(jif.Instruction), 32'h1);
        chk("rst_tdoen", 32'(jif.TDOEn), 32'h0);
        chk("rst_tdo", 32'(jif.TDO), 32'h0);
        chk("rst_user_dr_out", 32'(jif.UserDROut), 32'h00);
        chk("rst_user_update", 32'(jif.UserUpdate), 32'h0);
        TRSTn = 1'b1;
        idle(1);

        // IDCODE readout straight after reset
        capture_dr();
        shift_dr(64'h0, 32, -1);
        idle(2);
        chk("tdoen_after_idcode", 32'(jif.TDOEn), 32'h0);

        // All-ones IR gives BYPASS; IR capture pattern comes out first
        load_ir(4'b1111);
        chk("instruction_bypass", 32'(jif.Instruction), 32'hF);
        capture_dr();
        shift_dr(64'b1101, 4, -1);
        idle(1);

        // USER capture, shift and update
        jif.UserDRIn = 8'hA5;
        load_ir(4'b0010);
        capture_dr();
        shift_dr(64'h3C, 8, -1);
        update_dr();
        chk("user_dr_out_3c", 32'(jif.UserDROut), 32'h3C);

        // Resetn reloads IDCODE but keeps the update latch
        jif.Resetn = 1'b0;
        cyc();
        jif.Resetn = 1'b1;
        m_instr = 4'b0001;
        chk("resetn_instruction", 32'(jif.Instruction), 32'h1);
        chk("resetn_user_dr_out", 32'(jif.UserDROut), 32'h3C);
        load_ir(4'b0111);
        capture_dr();
        shift_dr(64'b101101, 6, 3);
        update_dr();
        idle(1);

        // TRSTn in the middle of a USER shift
        jif.UserDRIn = 8'h5A;
        load_ir(4'b0010);
        capture_dr();
        shift_dr(64'hFF, 3, -1);
        jif.ShiftDR = 1'b1;
        jif.TDI     = 1'b1;
        #2;
        TRSTn = 1'b0;
        #1;
        model_reset();
        chk("abort_instruction", 32'(jif.Instruction), 32'h1);
        chk("abort_tdoen", 32'(jif.TDOEn), 32'h0);
        chk("abort_tdo", 32'(jif.TDO), 32'h0);
        chk("abort_user_dr_out", 32'(jif.UserDROut), 32'h00);
        chk("abort_user_update", 32'(jif.UserUpdate), 32'h0);
        jif.ShiftDR = 1'b0;
        cyc();
        chk("abort_user_update_later", 32'(jif.UserUpdate), 32'h0);
        TRSTn = 1'b1;
        idle(1);
        jif.UserDRIn = 8'hC3;
        load_ir(4'b0010);
        capture_dr();
        shift_dr(64'h0, 8, -1);
        idle(1);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       op = 4'b0001;
                1:       op = 4'b0010;
                2:       op = 4'b1111;
                default: op = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 4) == 0) begin
                rd = {$urandom(), $urandom()};
                capture_ir();
                shift_ir(rd, $urandom_range(1, 7));
                update_ir();
            end else begin
                load_ir(op);
            end
            jif.UserDRIn = 8'($urandom());
            capture_dr();
            rd = {$urandom(), $urandom()};
            n  = $urandom_range(1, 40);
            p  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            shift_dr(rd, n, p);
            if ($urandom_range(0, 1) == 1) update_dr();
            idle($urandom_range(1, 2));
        end

        idle(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
